mem_arbiter: RTL and testbench

//  Shares the single simulated memory port between the core's instruction-fetch (IF, read-only) and

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IF/LS memory-port arbiter.
package mem_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int MASK_W = 4;

  localparam logic MEM_CMD_READ  = 1'b0;
  localparam logic MEM_CMD_WRITE = 1'b1;

  typedef enum logic {
    ARB_ID_IF = 1'b0,
    ARB_ID_LS = 1'b1
  } arb_id_e;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the IF/LS requester handshakes and the simulated memory port.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic              if_req_valid;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_req_ready;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_data;
  logic              if_rsp_err;

  logic              ls_req_valid;
  logic              ls_req_cmd;
  logic [ADDR_W-1:0] ls_req_addr;
  logic [MASK_W-1:0] ls_req_mask;
  logic [DATA_W-1:0] ls_req_wdata;
  logic              ls_req_ready;
  logic              ls_rsp_valid;
  logic [DATA_W-1:0] ls_rsp_data;
  logic              ls_rsp_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [MASK_W-1:0] mem_mask;
  logic              mem_enable;
  logic              mem_cmd;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_load_data;
  logic              mem_valid;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    input  ls_req_valid, ls_req_cmd, ls_req_addr, ls_req_mask, ls_req_wdata,
    output ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
    output mem_addr, mem_mask, mem_enable, mem_cmd, mem_write_data,
    input  mem_load_data, mem_valid
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    output ls_req_valid, ls_req_cmd, ls_req_addr, ls_req_mask, ls_req_wdata,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
    input  mem_addr, mem_mask, mem_enable, mem_cmd, mem_write_data,
    output mem_load_data, mem_valid
  );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store: LS priority,
// IF starvation guard, one registered access and one response pulse per transaction.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  arb_state_e        state_q, state_nxt;
  logic [3:0]        starve_cnt;
  logic              if_grant, ls_grant, req_err;
  logic              if_rsp_hit, ls_rsp_hit;

  arb_id_e           id_p0;
  logic              cmd_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [MASK_W-1:0] mask_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic              err_p0;
  logic [DATA_W-1:0] rdata_p1;

  // Full words must be aligned; halfwords and bytes are judged by lane pattern alone.
  function automatic logic ls_legal(input logic [MASK_W-1:0] mask, input logic [1:0] lsb);
    case (mask)
      4'b1111:                                              ls_legal = (lsb == 2'b00);
      4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000: ls_legal = 1'b1;
      default:                                              ls_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    sat_inc = (v == 4'hF) ? v : v + 4'd1;
  endfunction

  always_comb begin
    state_nxt = state_q;
    if_grant  = 1'b0;
    ls_grant  = 1'b0;
    req_err   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (!reset) begin
          if (bus.if_req_valid && (!bus.ls_req_valid || starve_cnt == STARVE_MAX)) if_grant = 1'b1;
          else if (bus.ls_req_valid)                                                ls_grant = 1'b1;
          if (if_grant)      req_err = (bus.if_req_addr[1:0] != 2'b00);
          else if (ls_grant) req_err = !ls_legal(bus.ls_req_mask, bus.ls_req_addr[1:0]);
          if (if_grant || ls_grant) state_nxt = req_err ? ARB_RESP : ARB_ACCESS;
        end
      end
      ARB_ACCESS: state_nxt = ARB_RESP;
      ARB_RESP:   state_nxt = ARB_IDLE;
      default:    state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      starve_cnt <= 4'd0;
      id_p0      <= ARB_ID_IF;
      cmd_p0     <= MEM_CMD_READ;
      addr_p0    <= '0;
      mask_p0    <= '0;
      wdata_p0   <= '0;
      err_p0     <= 1'b0;
      rdata_p1   <= '0;
    end else begin
      state_q <= state_nxt;
      if (!bus.if_req_valid || if_grant) starve_cnt <= 4'd0;
      else if (ls_grant)                 starve_cnt <= sat_inc(starve_cnt);
      // p0: accept - latch the winning request
      if (if_grant) begin
        id_p0    <= ARB_ID_IF;
        cmd_p0   <= MEM_CMD_READ;
        addr_p0  <= bus.if_req_addr;
        mask_p0  <= 4'hF;
        wdata_p0 <= '0;
        err_p0   <= req_err;
        rdata_p1 <= '0;
      end else if (ls_grant) begin
        id_p0    <= ARB_ID_LS;
        cmd_p0   <= bus.ls_req_cmd;
        addr_p0  <= bus.ls_req_addr;
        mask_p0  <= bus.ls_req_mask;
        wdata_p0 <= bus.ls_req_wdata;
        err_p0   <= req_err;
        rdata_p1 <= '0;
      // p1: access - capture the read word for the response
      end else if (state_q == ARB_ACCESS && cmd_p0 == MEM_CMD_READ) begin
        rdata_p1 <= bus.mem_load_data;
      end
    end
  end

  assign bus.if_req_ready   = if_grant;
  assign bus.ls_req_ready   = ls_grant;

  assign bus.mem_enable     = (state_q == ARB_ACCESS) && !reset;
  assign bus.mem_addr       = addr_p0;
  assign bus.mem_mask       = mask_p0;
  assign bus.mem_cmd        = cmd_p0;
  assign bus.mem_write_data = wdata_p0;

  // p2: response - one pulse to the winner; reset abandons it
  assign if_rsp_hit       = (state_q == ARB_RESP) && (id_p0 == ARB_ID_IF) && !reset;
  assign ls_rsp_hit       = (state_q == ARB_RESP) && (id_p0 == ARB_ID_LS) && !reset;
  assign bus.if_rsp_valid = if_rsp_hit;
  assign bus.if_rsp_data  = if_rsp_hit ? rdata_p1 : '0;
  assign bus.if_rsp_err   = if_rsp_hit && err_p0;
  assign bus.ls_rsp_valid = ls_rsp_hit;
  assign bus.ls_rsp_data  = ls_rsp_hit ? rdata_p1 : '0;
  assign bus.ls_rsp_err   = ls_rsp_hit && err_p0;

  a_mem_valid: assert property (@(posedge clk) disable iff (reset)
    bus.mem_valid == (state_q == ARB_ACCESS && cmd_p0 == MEM_CMD_READ));

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int STARVE_LIMIT = 4;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic mem_init = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();
  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Simulated memory: 64 words, combinational read, level write at the clock edge.
  logic [31:0] mem [64];

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'hDEADBEEF;
    if (i == 2)  return 32'h11223344;
    return 32'hA5000000 ^ (32'(i) * 32'h00010101);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (bus.mem_enable && bus.mem_cmd == MEM_CMD_WRITE) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_mask[b]) mem[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_write_data[8*b +: 8];
    end
  end

  assign bus.mem_valid     = bus.mem_enable && (bus.mem_cmd == MEM_CMD_READ);
  assign bus.mem_load_data = bus.mem_valid ? mem[bus.mem_addr[7:2]] : 32'h0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state: at most one transaction in flight, tracked by cycle stamps.
  int          cyc     = 0;
  int          rsp_cyc = -1;
  int          en_cyc  = -1;
  int          starve  = 0;
  int          rsp_id  = 0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] ex_addr, ex_wdata;
  logic [3:0]  ex_mask;
  logic        ex_cmd;
  logic [31:0] ref_mem [64];

  bit          if_pend = 0, ls_pend = 0;
  logic [31:0] if_a = '0, ls_a = '0, ls_w = '0;
  logic [3:0]  ls_m = '0;
  logic        ls_c = 1'b0;
  int          if_pct = 0, ls_pct = 0, err_pct = 0;
  bit          ls_rd_only = 0;
  bit          rst_next = 1;

  int          g_id[$];
  int          g_cyc[$];
  int          en_cnt = 0;
  logic [31:0] last_if_data = '0, last_ls_data = '0;

  logic [3:0]  legal_t   [7] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
  logic [3:0]  illegal_t [6] = '{4'h0, 4'h6, 4'h5, 4'hA, 4'h7, 4'hE};

  function automatic bit legal_ls(input logic [3:0] m, input logic [31:0] a);
    if (m == 4'hF) return a[1:0] == 2'b00;
    return m inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC};
  endfunction

  function automatic bit roll(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  task automatic new_if();
    logic [5:0] idx;
    logic [1:0] lo;
    idx     = 6'($urandom_range(63));
    lo      = roll(err_pct) ? 2'($urandom_range(3, 1)) : 2'b00;
    if_a    = {24'h0, idx, lo};
    if_pend = 1;
  endtask

  task automatic new_ls();
    logic [5:0] idx;
    logic [1:0] lo;
    int         k;
    idx  = 6'($urandom_range(63));
    ls_c = ls_rd_only ? MEM_CMD_READ : 1'($urandom_range(1));
    ls_w = $urandom;
    if (roll(err_pct)) begin
      k = int'($urandom_range(6));
      if (k == 6) begin ls_m = 4'hF; lo = 2'($urandom_range(3, 1)); end
      else begin ls_m = illegal_t[k]; lo = 2'($urandom_range(3)); end
    end else begin
      k    = int'($urandom_range(6));
      ls_m = legal_t[k];
      lo   = (ls_m == 4'hF) ? 2'b00 : 2'($urandom_range(3));
    end
    ls_a    = {24'h0, idx, lo};
    ls_pend = 1;
  endtask

  task automatic step();
    bit gi, gl, idle, err, if_v;
    @(negedge clk);
    reset = rst_next;
    if (reset) begin
      if_pend = 0; ls_pend = 0; rsp_cyc = -1; en_cyc = -1; starve = 0;
    end else begin
      if (!if_pend && roll(if_pct)) new_if();
      if (!ls_pend && roll(ls_pct)) new_ls();
    end
    bus.if_req_valid = if_pend;
    bus.if_req_addr  = if_a;
    bus.ls_req_valid = ls_pend;
    bus.ls_req_cmd   = ls_c;
    bus.ls_req_addr  = ls_a;
    bus.ls_req_mask  = ls_m;
    bus.ls_req_wdata = ls_w;
    #1;
    if (bus.mem_enable)   en_cnt++;
    if (bus.if_rsp_valid) last_if_data = bus.if_rsp_data;
    if (bus.ls_rsp_valid) last_ls_data = bus.ls_rsp_data;
    if (reset) begin
      check("rst_if_ready",   32'(bus.if_req_ready), 32'd0);
      check("rst_ls_ready",   32'(bus.ls_req_ready), 32'd0);
      check("rst_mem_enable", 32'(bus.mem_enable),   32'd0);
      check("rst_if_rsp",     32'(bus.if_rsp_valid), 32'd0);
      check("rst_ls_rsp",     32'(bus.ls_rsp_valid), 32'd0);
    end else begin
      if_v = if_pend;
      idle = cyc > rsp_cyc;
      gi   = idle && if_pend && (!ls_pend || starve == STARVE_LIMIT);
      gl   = idle && ls_pend && !gi;
      check("if_ready",   32'(bus.if_req_ready), 32'(gi));
      check("ls_ready",   32'(bus.ls_req_ready), 32'(gl));
      check("mem_enable", 32'(bus.mem_enable),   32'(cyc == en_cyc));
      if (cyc == en_cyc) begin
        check("mem_addr",  bus.mem_addr,         ex_addr);
        check("mem_mask",  32'(bus.mem_mask),    32'(ex_mask));
        check("mem_cmd",   32'(bus.mem_cmd),     32'(ex_cmd));
        check("mem_wdata", bus.mem_write_data,   ex_wdata);
        if (ex_cmd == MEM_CMD_WRITE)
          for (int b = 0; b < 4; b++)
            if (ex_mask[b]) ref_mem[ex_addr[7:2]][8*b +: 8] = ex_wdata[8*b +: 8];
      end
      check("if_rsp_valid", 32'(bus.if_rsp_valid), 32'(cyc == rsp_cyc && rsp_id == 0));
      check("ls_rsp_valid", 32'(bus.ls_rsp_valid), 32'(cyc == rsp_cyc && rsp_id == 1));
      if (cyc == rsp_cyc && rsp_id == 0) begin
        check("if_rsp_data", bus.if_rsp_data,     rsp_data);
        check("if_rsp_err",  32'(bus.if_rsp_err), 32'(rsp_err));
      end
      if (cyc == rsp_cyc && rsp_id == 1) begin
        check("ls_rsp_data", bus.ls_rsp_data,     rsp_data);
        check("ls_rsp_err",  32'(bus.ls_rsp_err), 32'(rsp_err));
      end
      if (gi || gl) begin
        if (gi) begin
          ex_cmd = MEM_CMD_READ; ex_addr = if_a; ex_mask = 4'hF; ex_wdata = '0;
          err = (if_a[1:0] != 2'b00); rsp_id = 0; if_pend = 0;
        end else begin
          ex_cmd = ls_c; ex_addr = ls_a; ex_mask = ls_m; ex_wdata = ls_w;
          err = !legal_ls(ls_m, ls_a); rsp_id = 1; ls_pend = 0;
        end
        rsp_err  = err;
        rsp_data = (err || ex_cmd == MEM_CMD_WRITE) ? 32'h0 : ref_mem[ex_addr[7:2]];
        en_cyc   = err ? -1 : cyc + 1;
        rsp_cyc  = err ? cyc + 1 : cyc + 2;
        g_id.push_back(rsp_id);
        g_cyc.push_back(cyc);
      end
      if (!if_v || gi)            starve = 0;
      else if (gl && starve < 15) starve++;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int          e0, n;
    logic [31:0] pre;

    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    bus.if_req_valid = 0; bus.if_req_addr = '0;
    bus.ls_req_valid = 0; bus.ls_req_cmd = 0; bus.ls_req_addr = '0;
    bus.ls_req_mask = '0; bus.ls_req_wdata = '0;

    rst_next = 1;
    step();
    mem_init = 0;
    step();
    check("reset_mem_addr",  bus.mem_addr,            32'h0);
    check("reset_mem_mask",  32'(bus.mem_mask),       32'h0);
    check("reset_mem_cmd",   32'(bus.mem_cmd),        32'h0);
    check("reset_mem_wdata", bus.mem_write_data,      32'h0);
    check("reset_if_data",   bus.if_rsp_data,         32'h0);
    check("reset_ls_err",    32'(bus.ls_rsp_err),     32'h0);
    rst_next = 0;

    // IF read of word 16
    if_pend = 1; if_a = 32'h40;
    run(4);
    check("t1_if_data", last_if_data, 32'hDEADBEEF);

    // LS byte-lane write then IF readback
    ls_pend = 1; ls_c = MEM_CMD_WRITE; ls_a = 32'h8; ls_m = 4'b0100; ls_w = 32'h00AB0000;
    last_ls_data = 32'hFFFFFFFF;
    run(3);
    check("t2_ls_rsp_data", last_ls_data, 32'h0);
    check("t2_mem_word",    mem[2],       32'h11AB3344);
    if_pend = 1; if_a = 32'h8;
    run(3);
    check("t2_readback", last_if_data, 32'h11AB3344);

    // Rejected requests never touch memory
    e0 = en_cnt;
    if_pend = 1; if_a = 32'h42;
    run(2);
    ls_pend = 1; ls_c = MEM_CMD_WRITE; ls_a = 32'h8; ls_m = 4'b0110; ls_w = 32'hFFFFFFFF;
    run(2);
    check("t4_no_access", 32'(en_cnt - e0), 32'd0);
    check("t4_mem_kept",  mem[2],           32'h11AB3344);

    // Back-to-back LS reads held valid
    ls_rd_only = 1; ls_pct = 100; err_pct = 0;
    g_id.delete(); g_cyc.delete();
    run(20);
    ls_pct = 0;
    run(6);
    check("t6_count", 32'(g_cyc.size() >= 6), 32'd1);
    for (int i = 1; i < g_cyc.size(); i++) check("t6_gap", 32'(g_cyc[i] - g_cyc[i-1]), 32'd3);

    // Reset during the ACCESS cycle of an LS write, with the starve counter nonzero
    ls_rd_only = 0; if_pct = 100; ls_pct = 100;
    g_id.delete(); g_cyc.delete();
    n = 0;
    while (g_id.size() < 2 && n < 20) begin step(); n++; end
    check("t5_setup", 32'(g_id.size()), 32'd2);
    if_pct = 0; ls_pct = 0;
    ls_pend = 1; ls_c = MEM_CMD_WRITE; ls_a = 32'hA0; ls_m = 4'hF; ls_w = 32'hCAFEF00D;
    n = 0;
    while (g_id.size() < 3 && n < 20) begin step(); n++; end
    check("t5_ls_won", 32'(g_id.size() == 3 && g_id[g_id.size()-1] == 1), 32'd1);
    pre = mem[40];
    rst_next = 1;
    step();
    step();
    check("t5_mem_addr",  bus.mem_addr,            32'h0);
    check("t5_mem_mask",  32'(bus.mem_mask),       32'h0);
    check("t5_mem_wdata", bus.mem_write_data,      32'h0);
    check("t5_ls_data",   bus.ls_rsp_data,         32'h0);
    rst_next = 0;
    run(4);
    check("t5_mem_kept",  mem[40],                 pre);
    check("t5_no_accept", 32'(g_id.size()),        32'd3);

    // Both requesters held valid: starvation guard pattern from a cleared counter
    g_id.delete(); g_cyc.delete();
    new_if(); new_ls();
    if_pct = 100; ls_pct = 100;
    n = 0;
    while (g_id.size() < 10 && n < 60) begin step(); n++; end
    check("t3_grants", 32'(g_id.size() >= 10), 32'd1);
    for (int i = 0; i < 10 && i < g_id.size(); i++)
      check("t3_winner", 32'(g_id[i]), (i % 5 == 4) ? 32'd0 : 32'd1);

    // Random traffic
    if_pct = 40; ls_pct = 50; err_pct = 15;
    run(800);
    if_pct = 0; ls_pct = 0;
    run(10);
    for (int i = 0; i < 64; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
